// File: rtl/chi_plane_seq_pkg.sv
// Shared definitions for the row-serial 2-share chi plane driver: row width,
// FSM state encoding and row slicing helper.
package chi_plane_seq_pkg;

  localparam int CHI_ROW_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LSB position of row r inside a packed plane.
  function automatic int row_lsb(input int r);
    return r * CHI_ROW_W;
  endfunction

endpackage

// File: rtl/chi_plane_seq_chi_no_fresh.sv
// 2-share Keccak chi row core without fresh randomness; one registered stage.
// Cross-share terms are formed only through AND so the shares are never recombined.
module chi_no_fresh
  import chi_plane_seq_pkg::*;
(
  input  logic                 clk,
  input  logic [CHI_ROW_W-1:0] a,
  input  logic [CHI_ROW_W-1:0] b,
  output logic [CHI_ROW_W-1:0] y_a,
  output logic [CHI_ROW_W-1:0] y_b
);

  logic [CHI_ROW_W-1:0] ya_c, yb_c;

  always_comb begin
    ya_c = '0;
    yb_c = '0;
    for (int i = 0; i < CHI_ROW_W; i++) begin
      ya_c[i] = a[i] ^ (~a[(i+1)%CHI_ROW_W] & a[(i+2)%CHI_ROW_W])
                     ^ ( a[(i+1)%CHI_ROW_W] & b[(i+2)%CHI_ROW_W]);
      yb_c[i] = b[i] ^ (~b[(i+1)%CHI_ROW_W] & b[(i+2)%CHI_ROW_W])
                     ^ ( b[(i+1)%CHI_ROW_W] & a[(i+2)%CHI_ROW_W]);
    end
  end

  // core output register
  always_ff @(posedge clk) begin
    y_a <= ya_c;
    y_b <= yb_c;
  end

endmodule

// File: rtl/chi_plane_seq.sv
// Row-serial driver: buffers a 2-share plane, feeds one row per cycle into the
// shared chi core, collects result rows and presents the plane on valid/ready.
module chi_plane_seq
  import chi_plane_seq_pkg::*;
#(
  parameter int ROWS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHI_ROW_W*ROWS-1:0] in_s1,
  input  logic [CHI_ROW_W*ROWS-1:0] in_s2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHI_ROW_W*ROWS-1:0] out_s1,
  output logic [CHI_ROW_W*ROWS-1:0] out_s2,
  output logic                      busy
);

  localparam int                W     = CHI_ROW_W * ROWS;
  localparam int                IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(ROWS - 1);

  state_t               state;
  logic [W-1:0]         buf_s1, buf_s2;
  logic [IDX_W-1:0]     ridx, widx;
  logic [CHI_ROW_W-1:0] sel_s1, sel_s2;
  logic [CHI_ROW_W-1:0] row_s1_p0, row_s2_p0;
  logic [CHI_ROW_W-1:0] res_s1_p1, res_s2_p1;
  logic                 vld_p0, vld_p1;

  always_comb begin
    sel_s1 = '0;
    sel_s2 = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (ridx == IDX_W'(r)) begin
        sel_s1 = buf_s1[row_lsb(r) +: CHI_ROW_W];
        sel_s2 = buf_s2[row_lsb(r) +: CHI_ROW_W];
      end
    end
  end

  // p0 -> p1: registered row core
  chi_no_fresh u_core (
    .clk (clk),
    .a   (row_s1_p0),
    .b   (row_s2_p0),
    .y_a (res_s1_p1),
    .y_b (res_s2_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      buf_s1    <= '0;
      buf_s2    <= '0;
      row_s1_p0 <= '0;
      row_s2_p0 <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      ridx      <= '0;
      widx      <= '0;
      out_s1    <= '0;
      out_s2    <= '0;
    end else begin
      // feed register is zero outside FEED so no stale row reaches the core
      row_s1_p0 <= '0;
      row_s2_p0 <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= vld_p0;

      // p1 capture into output buffers, overlapping with feeding
      if (vld_p1) begin
        for (int r = 0; r < ROWS; r++) begin
          if (widx == IDX_W'(r)) begin
            out_s1[row_lsb(r) +: CHI_ROW_W] <= res_s1_p1;
            out_s2[row_lsb(r) +: CHI_ROW_W] <= res_s2_p1;
          end
        end
        widx <= (widx == LAST) ? '0 : widx + IDX_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            buf_s1   <= in_s1;
            buf_s2   <= in_s2;
            ridx     <= '0;
            widx     <= '0;
            state    <= ST_FEED;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_FEED: begin
          row_s1_p0 <= sel_s1;
          row_s2_p0 <= sel_s2;
          vld_p0    <= 1'b1;
          if (ridx == LAST) begin
            ridx  <= '0;
            state <= ST_DRAIN;
          end else begin
            ridx <= ridx + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (vld_p1 && widx == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chi_plane_seq.sv
// Self-checking bench for chi_plane_seq: directed scenarios plus a randomized
// stream scored against an unshared golden chi computed on x = s1 ^ s2.
module tb_chi_plane_seq;

  localparam int ROWS = 5;
  localparam int W    = 5 * ROWS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_s1, in_s2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s1, out_s2;
  logic         busy;

  int checks = 0;
  int errors = 0;

  chi_plane_seq #(.ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s1     (in_s1),
    .in_s2     (in_s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s1    (out_s1),
    .out_s2    (out_s2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] golden(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = '0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < 5; i++)
        y[5*r+i] = x[5*r+i] ^ (~x[5*r+(i+1)%5] & x[5*r+(i+2)%5]);
    return y;
  endfunction

  function automatic logic [W-1:0] rndw();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic run_plane(input logic [W-1:0] s1, input logic [W-1:0] s2,
                           input string tag, output logic [W-1:0] xo);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_s1 = s1; in_s2 = s2;
    @(negedge clk);
    in_valid = 1'b0; in_s1 = rndw(); in_s2 = rndw();
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, ROWS + 2);
    xo = out_s1 ^ out_s2;
    chk({tag, "_result"}, xo, golden(s1 ^ s2));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic stream(input int nplanes, input bit rnd, input string tag);
    logic [W-1:0] q[$];
    logic [W-1:0] x, s1, held1, held2;
    int  acc, got, cyc;
    bit  regen, hold;
    acc = 0; got = 0; cyc = 0; regen = 1'b1; hold = 1'b0;
    held1 = '0; held2 = '0; x = '0;
    while (got < nplanes && cyc < nplanes * 40) begin
      if (regen) begin
        x = rndw(); s1 = rndw();
        in_s1 = s1; in_s2 = s1 ^ x;
        regen = 1'b0;
      end
      if (rnd) begin
        in_valid  = (acc < nplanes) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 1) == 1);
      end else begin
        in_valid  = (acc < nplanes);
        out_ready = 1'b1;
      end
      if (hold) begin
        chk({tag, "_hold_s1"}, out_s1, held1);
        chk({tag, "_hold_s2"}, out_s2, held2);
      end
      if (out_valid) chk({tag, "_rdy_in_done"}, in_ready, 0);
      if (out_valid && out_ready) begin
        chk({tag, "_ov_has_accept"}, q.size() > 0, 1);
        if (q.size() > 0) chk({tag, "_result"}, out_s1 ^ out_s2, q.pop_front());
        got++;
      end
      hold  = out_valid && !out_ready;
      held1 = out_s1;
      held2 = out_s2;
      if (in_valid && in_ready) begin
        q.push_back(golden(x));
        acc++;
        regen = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, got, nplanes);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s, x, xo, sv1, sv2;
    rst = 1'b1; in_valid = 1'b0; in_s1 = '0; in_s2 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_s1", out_s1, 0);
    chk("rst_out_s2", out_s2, 0);
    rst = 1'b0;
    @(negedge clk);

    // all-zero x with random equal shares
    s = rndw();
    run_plane(s, s, "zero", xo);
    chk("zero_const", xo, 0);
    release_out("zero");

    // row0 = 01, others 1F
    x = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h01};
    s = rndw();
    run_plane(s, s ^ x, "row01", xo);
    chk("row01_const", xo, {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h09});
    release_out("row01");

    // hold in DONE with out_ready low; new in_valid must be ignored
    s = rndw();
    run_plane(s, rndw(), "hold", xo);
    sv1 = out_s1; sv2 = out_s2;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_s1 = rndw(); in_s2 = rndw();
      @(negedge clk);
      chk("hold_ov", out_valid, 1);
      chk("hold_s1", out_s1, sv1);
      chk("hold_s2", out_s2, sv2);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out("hold");

    // reset mid-FEED after two rows loaded; in_valid during reset ignored
    in_valid = 1'b1; in_s1 = rndw(); in_s2 = rndw();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ov", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("midrst_no_partial", out_valid, 0);
    end
    chk("midrst_still_idle", busy, 0);
    s = rndw();
    run_plane(s, rndw(), "fresh", xo);
    release_out("fresh");

    stream(3, 1'b0, "b2b");
    stream(1000, 1'b1, "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
